// File: rtl/iline_prefetcher_pkg.sv
// Shared types and sizes for the next-line instruction prefetcher and its cache.
package iline_prefetcher_pkg;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HIT      = 3'd1,
    DEMAND   = 3'd2,
    WRITE    = 3'd3,
    RESP     = 3'd4,
    PREFETCH = 3'd5
  } pf_state_t;

endpackage

// File: rtl/iline_prefetcher.sv
// Next-line instruction prefetcher: one-entry line buffer between the I-cache miss
// port and slow memory; every demand fetch or buffer hit launches a fetch of line+1.
module iline_prefetcher
  import iline_prefetcher_pkg::*;
#(
  parameter int unsigned ADDR_W = iline_prefetcher_pkg::ADDR_W,
  parameter int unsigned LINE_W = iline_prefetcher_pkg::LINE_W,
  parameter bit          PF_EN  = 1'b1,
  parameter int unsigned CNT_W  = iline_prefetcher_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_read,
  input  logic              c_write,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [LINE_W-1:0] c_wdata,
  output logic [LINE_W-1:0] c_rdata,
  output logic              c_ready,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  pf_hits
);

  pf_state_t         state_q, state_d;
  logic              c_ready_q, c_ready_d;
  logic [LINE_W-1:0] c_rdata_q, c_rdata_d;
  logic              m_read_q, m_read_d;
  logic              m_write_q, m_write_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [LINE_W-1:0] m_wdata_q, m_wdata_d;
  logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_tag_q, buf_tag_d;
  logic [LINE_W-1:0] buf_data_q, buf_data_d;
  logic [CNT_W-1:0]  pf_hits_q, pf_hits_d;

  logic [ADDR_W-1:0] nxt_addr;
  logic              buf_match;

  // Line address wraps modulo 2^ADDR_W.
  assign nxt_addr  = c_addr + ADDR_W'(1);
  assign buf_match = buf_valid_q && (buf_tag_q == c_addr);

  always_comb begin
    state_d     = state_q;
    c_ready_d   = 1'b0;
    c_rdata_d   = c_rdata_q;
    m_read_d    = m_read_q;
    m_write_d   = m_write_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    pf_addr_d   = pf_addr_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    pf_hits_d   = pf_hits_q;

    unique case (state_q)
      // A request still high during the c_ready cycle is the one just served.
      IDLE: begin
        if (!c_ready_q) begin
          if (c_write) begin
            state_d   = WRITE;
            m_write_d = 1'b1;
            m_addr_d  = c_addr;
            m_wdata_d = c_wdata;
          end else if (c_read) begin
            if (buf_match) begin
              state_d = HIT;
            end else begin
              state_d  = DEMAND;
              m_read_d = 1'b1;
              m_addr_d = c_addr;
            end
          end
        end
      end
      HIT: begin
        c_ready_d = 1'b1;
        c_rdata_d = buf_data_q;
        pf_hits_d = (&pf_hits_q) ? pf_hits_q : pf_hits_q + CNT_W'(1);
        pf_addr_d = nxt_addr;
        if (PF_EN) begin
          state_d  = PREFETCH;
          m_read_d = 1'b1;
          m_addr_d = nxt_addr;
        end else begin
          state_d = IDLE;
        end
      end
      DEMAND: begin
        if (m_ready) begin
          state_d   = RESP;
          c_rdata_d = m_rdata;
          c_ready_d = 1'b1;
          m_read_d  = 1'b0;
        end
      end
      RESP: begin
        pf_addr_d = nxt_addr;
        if (PF_EN) begin
          state_d  = PREFETCH;
          m_read_d = 1'b1;
          m_addr_d = nxt_addr;
        end else begin
          state_d = IDLE;
        end
      end
      PREFETCH: begin
        if (m_ready) begin
          state_d     = IDLE;
          m_read_d    = 1'b0;
          buf_valid_d = 1'b1;
          buf_tag_d   = pf_addr_q;
          buf_data_d  = m_rdata;
        end
      end
      WRITE: begin
        if (m_ready) begin
          state_d   = IDLE;
          m_write_d = 1'b0;
          c_ready_d = 1'b1;
          if (buf_match) begin
            buf_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        m_read_d  = 1'b0;
        m_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      c_ready_q   <= 1'b0;
      c_rdata_q   <= '0;
      m_read_q    <= 1'b0;
      m_write_q   <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      pf_addr_q   <= '0;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      pf_hits_q   <= '0;
    end else begin
      state_q     <= state_d;
      c_ready_q   <= c_ready_d;
      c_rdata_q   <= c_rdata_d;
      m_read_q    <= m_read_d;
      m_write_q   <= m_write_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      pf_addr_q   <= pf_addr_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      pf_hits_q   <= pf_hits_d;
    end
  end

  assign c_ready = c_ready_q;
  assign c_rdata = c_rdata_q;
  assign m_read  = m_read_q;
  assign m_write = m_write_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign pf_hits = pf_hits_q;

endmodule

// File: tb/tb_iline_prefetcher.sv
// Bench for iline_prefetcher: a prefetching and a non-prefetching instance, each with
// its own latency-programmable memory, checked against a transaction-level model.
module tb_iline_prefetcher;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  logic         c_read  [2];
  logic         c_write [2];
  logic [27:0]  c_addr  [2];
  logic [127:0] c_wdata [2];
  logic [127:0] c_rdata [2];
  logic         c_ready [2];
  logic         m_read  [2];
  logic         m_write [2];
  logic [27:0]  m_addr  [2];
  logic [127:0] m_wdata [2];
  logic [127:0] m_rdata [2];
  logic         m_ready [2];
  logic [15:0]  pf_hits [2];

  int n_checks = 0;
  int n_errors = 0;

  // Model state per instance (0: prefetch on, 1: prefetch off)
  int           lat    [2];
  bit           m_bv   [2];
  logic [27:0]  m_tag  [2];
  logic [127:0] m_data [2];
  logic [15:0]  m_hits [2];
  int           m_f    [2];
  logic [27:0]  la     [2];
  logic [127:0] ref_mem [logic [28:0]];
  logic [127:0] tb_mem  [logic [28:0]];
  logic [27:0]  exp_rd0[$], exp_rd1[$], act_rd0[$], act_rd1[$];

  logic [27:0] dir_addr [8] = '{28'h0000010, 28'h0000011, 28'h0000012, 28'h0000200,
                                28'h0000201, 28'h0000201, 28'hFFFFFFF, 28'h0000000};
  bit          dir_wr   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  int          dir_gap  [8] = '{1, 1, 14, 14, 14, 2, 14, 14};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iline_prefetcher #(.PF_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .c_read(c_read[0]), .c_write(c_write[0]), .c_addr(c_addr[0]),
    .c_wdata(c_wdata[0]), .c_rdata(c_rdata[0]), .c_ready(c_ready[0]), .m_read(m_read[0]),
    .m_write(m_write[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]), .m_rdata(m_rdata[0]),
    .m_ready(m_ready[0]), .pf_hits(pf_hits[0]));

  iline_prefetcher #(.PF_EN(1'b0)) dut_nopf (
    .clk(clk), .rst_n(rst_n), .c_read(c_read[1]), .c_write(c_write[1]), .c_addr(c_addr[1]),
    .c_wdata(c_wdata[1]), .c_rdata(c_rdata[1]), .c_ready(c_ready[1]), .m_read(m_read[1]),
    .m_write(m_write[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]), .m_rdata(m_rdata[1]),
    .m_ready(m_ready[1]), .pf_hits(pf_hits[1]));

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] init_line(input logic [28:0] k);
    logic [31:0] x, p;
    x = {3'b000, k} ^ 32'h5A5A_1234;
    p = x * 32'h9E37_79B1;
    return {p, ~x, x + 32'h1111_1111, {x[15:0], x[31:16]}};
  endfunction

  function automatic logic [127:0] ref_line(input logic [28:0] k);
    return ref_mem.exists(k) ? ref_mem[k] : init_line(k);
  endfunction

  function automatic void push_exp(input int u, input logic [27:0] a);
    if (u == 0) exp_rd0.push_back(a);
    else        exp_rd1.push_back(a);
  endfunction

  // Memory: a request first seen at a clock edge completes with m_ready lat cycles
  // after it became visible.
  int busy [2];
  int cnt  [2];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        m_ready[u] <= 1'b0;
        m_rdata[u] <= '0;
        busy[u]    <= 0;
        cnt[u]     <= 0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        bit fire;
        logic [28:0] key;
        fire = 1'b0;
        key  = {u[0], m_addr[u]};
        m_ready[u] <= 1'b0;
        if (m_read[u] || m_write[u]) check_eq("m_rw_excl", m_read[u] & m_write[u], 1'b0);
        if (busy[u] != 0) begin
          if (cnt[u] == 1) begin
            busy[u] <= 0;
            fire = 1'b1;
          end else begin
            cnt[u] <= cnt[u] - 1;
          end
        end else if ((m_read[u] || m_write[u]) && !m_ready[u]) begin
          if (lat[u] <= 1) fire = 1'b1;
          else begin
            busy[u] <= 1;
            cnt[u]  <= lat[u] - 1;
          end
        end
        if (fire) begin
          m_ready[u] <= 1'b1;
          if (m_read[u]) begin
            m_rdata[u] <= tb_mem.exists(key) ? tb_mem[key] : init_line(key);
            if (u == 0) act_rd0.push_back(m_addr[u]);
            else        act_rd1.push_back(m_addr[u]);
          end else begin
            tb_mem[key] = m_wdata[u];
          end
        end
      end
    end
  end

  // One cache transaction: predict outcome and completion cycle, drive, then compare.
  task automatic do_req(input int u, input bit wr, input logic [27:0] a, input int gap);
    logic [127:0] wd, exp_d;
    logic [27:0]  na;
    int r, s, L, exp_cyc, seen;
    bit got, pf;
    repeat (gap) @(negedge clk);
    wd = {$urandom, $urandom, $urandom, $urandom};
    pf = (u == 0);
    r  = cyc;
    L  = lat[u];
    s  = (r > m_f[u]) ? r : m_f[u];
    na = a + 28'd1;
    exp_d = '0;
    if (wr) begin
      exp_cyc = s + L + 2;
      ref_mem[{u[0], a}] = wd;
      if (m_bv[u] && m_tag[u] == a) m_bv[u] = 1'b0;
      m_f[u] = s + L + 3;
    end else if (m_bv[u] && m_tag[u] == a) begin
      exp_d   = m_data[u];
      exp_cyc = s + 2;
      if (m_hits[u] != 16'hFFFF) m_hits[u] = m_hits[u] + 16'd1;
      m_f[u]  = pf ? s + L + 3 : s + 3;
    end else begin
      exp_d   = ref_line({u[0], a});
      exp_cyc = s + L + 2;
      push_exp(u, a);
      m_f[u]  = pf ? s + 2 * L + 4 : s + L + 3;
    end
    if (!wr && pf) begin
      m_bv[u]   = 1'b1;
      m_tag[u]  = na;
      m_data[u] = ref_line({u[0], na});
      push_exp(u, na);
    end
    c_addr[u]  = a;
    c_wdata[u] = wd;
    c_write[u] = wr;
    c_read[u]  = !wr;
    got  = 1'b0;
    seen = 0;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      if (c_ready[u]) begin
        got  = 1'b1;
        seen = cyc;
      end
    end
    check_eq("c_ready_seen", got, 1'b1);
    check_eq("c_ready_cycle", seen, exp_cyc);
    if (!wr) check_eq("c_rdata", c_rdata[u], exp_d);
    @(posedge clk);
    #1;
    c_read[u]  = 1'b0;
    c_write[u] = 1'b0;
    @(negedge clk);
    check_eq("c_ready_pulse", c_ready[u], 1'b0);
    check_eq("pf_hits", pf_hits[u], m_hits[u]);
    la[u] = a;
  endtask

  task automatic run_inst(input int u);
    logic [27:0] a;
    logic [31:0] tmp;
    int sel;
    lat[u] = 4;
    for (int i = 0; i < 8; i++) do_req(u, dir_wr[i], dir_addr[i], dir_gap[i]);
    for (int b = 0; b < 4; b++) begin
      repeat (30) @(negedge clk);
      lat[u] = $urandom_range(1, 6);
      for (int i = 0; i < 25; i++) begin
        sel = $urandom_range(0, 9);
        tmp = $urandom;
        if (sel <= 4)      a = la[u] + 28'd1;
        else if (sel <= 6) a = la[u];
        else if (sel == 7) a = tmp[27:0];
        else if (sel == 8) a = 28'hFFFFFFF;
        else               a = la[u] + 28'd2;
        if (sel == 0) a = la[u] + 28'd1;
        do_req(u, sel == 0, a, $urandom_range(1, 4));
      end
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      c_read[u] = 1'b0; c_write[u] = 1'b0; c_addr[u] = '0; c_wdata[u] = '0;
      lat[u] = 4; m_bv[u] = 1'b0; m_tag[u] = '0; m_data[u] = '0;
      m_hits[u] = '0; m_f[u] = 0; la[u] = '0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check_eq("rst_c_ready", c_ready[u], 1'b0);
      check_eq("rst_m_read", m_read[u], 1'b0);
      check_eq("rst_m_write", m_write[u], 1'b0);
      check_eq("rst_c_rdata", c_rdata[u], '0);
      check_eq("rst_m_addr", m_addr[u], '0);
      check_eq("rst_pf_hits", pf_hits[u], '0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    fork
      run_inst(0);
      run_inst(1);
    join

    // Reset while a prefetch is outstanding: buffer and counter must be cleared.
    repeat (30) @(negedge clk);
    lat[0] = 3;
    do_req(0, 1'b0, 28'h0000300, 1);
    repeat (20) @(negedge clk);
    do_req(0, 1'b0, 28'h0000301, 1);
    check_eq("pf_inflight", m_read[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_m_read", m_read[0], 1'b0);
    check_eq("rst_async_pf_hits", pf_hits[0], '0);
    check_eq("rst_async_c_ready", c_ready[0], 1'b0);
    void'(exp_rd0.pop_back());
    for (int u = 0; u < 2; u++) begin
      m_bv[u] = 1'b0; m_hits[u] = '0; m_f[u] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_req(0, 1'b0, 28'h0000301, 1);
    repeat (20) @(negedge clk);
    do_req(0, 1'b0, 28'h0000302, 1);
    repeat (20) @(negedge clk);

    check_eq("rd_count_pf", act_rd0.size(), exp_rd0.size());
    for (int i = 0; i < exp_rd0.size() && i < act_rd0.size(); i++)
      check_eq("rd_addr_pf", act_rd0[i], exp_rd0[i]);
    check_eq("rd_count_nopf", act_rd1.size(), exp_rd1.size());
    for (int i = 0; i < exp_rd1.size() && i < act_rd1.size(); i++)
      check_eq("rd_addr_nopf", act_rd1[i], exp_rd1[i]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
